// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Default widths match the reference 64-bit PC / 32-bit instruction build.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 64;
  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_STEP    = FETCH_INSTR_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// Circular FIFO holding fetched {pc, instr} entries.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !reset) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction fetch with a prefetch queue toward decode.
// One cache request in flight; redirects flush and drop stale data.
module instr_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_enable,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_addr,
  output logic                     req_valid,
  output logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_ready,
  input  logic                     resp_valid,
  input  logic [INSTR_W-1:0]       resp_data,
  output logic                     out_valid,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int STEP  = INSTR_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = ADDR_W + INSTR_W;

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   w_fetch_pc_nxt;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [ADDR_W-1:0]   w_redir_pc;
  logic                r_stale;
  logic                w_stale_nxt;
  logic                r_outstanding;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_free;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [EW-1:0]       w_head;

  assign w_redir_pc = redirect_addr & ~ADDR_W'(STEP - 1);

  assign w_push = (r_state == WAIT) && resp_valid && !redirect_valid;
  assign w_pop  = out_valid && out_ready && !redirect_valid;

  assign w_cnt_nxt = redirect_valid ? '0
                   : w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Slot is reserved at issue, so count the in-flight request too.
  assign w_free = ({1'b0, w_cnt_nxt}
                   + (CNT_W+1)'(r_outstanding && !resp_valid))
                  < (CNT_W+1)'(DEPTH);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_stale_nxt    = r_stale;
    w_accept       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (redirect_valid) w_fetch_pc_nxt = w_redir_pc;
        if (fetch_enable && w_free) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (req_ready) begin
          w_accept    = 1'b1;
          w_stale_nxt = 1'b0;
          if (redirect_valid || r_stale) begin
            w_state_nxt = DISCARD;
          end else begin
            w_state_nxt    = WAIT;
            w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(STEP);
          end
        end else if (redirect_valid) begin
          w_stale_nxt = 1'b1;
        end
        if (redirect_valid) w_fetch_pc_nxt = w_redir_pc;
      end
      WAIT, DISCARD: begin
        if (redirect_valid) w_fetch_pc_nxt = w_redir_pc;
        if (resp_valid) begin
          w_state_nxt = (fetch_enable && w_free) ? ISSUE : IDLE;
        end else if (redirect_valid) begin
          w_state_nxt = DISCARD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_stale       <= 1'b0;
      r_outstanding <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_stale    <= w_stale_nxt;
      if (w_state_nxt == ISSUE && r_state != ISSUE)
        r_req_addr <= w_fetch_pc_nxt;
      if (w_accept)
        r_outstanding <= 1'b1;
      else if (resp_valid && (r_state == WAIT || r_state == DISCARD))
        r_outstanding <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  ({r_req_addr, resp_data}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign req_valid   = (r_state == ISSUE);
  assign req_addr    = r_req_addr;
  assign queue_count = w_count;
  assign out_valid   = (w_count != '0);
  assign out_pc      = out_valid ? w_head[EW-1:INSTR_W] : '0;
  assign out_instr   = out_valid ? w_head[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with hand-computed expectations.
// Cache responses are driven step by step from the single stimulus block.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [63:0] redirect_addr;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic [2:0]  queue_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .ADDR_W   (64),
    .INSTR_W  (32),
    .DEPTH    (4),
    .RESET_PC (64'h1000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .queue_count    (queue_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    chk({tag, "_req_addr"}, req_addr, 64'h1000);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    chk({tag, "_out_pc"}, out_pc, 64'd0);
    chk({tag, "_count"}, 64'(queue_count), 64'd0);
  endtask

  // Expects a pending request at addr, accepts it, answers with k=1.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data);
    chk("fill_req_valid", 64'(req_valid), 64'd1);
    chk("fill_req_addr", req_addr, addr);
    tick;
    resp_valid = 1'b1;
    resp_data  = data;
    tick;
    resp_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    out_ready      = 1'b0;
    tick;
    tick;
    chk_reset_state("rst");

    reset        = 1'b0;
    fetch_enable = 1'b1;
    req_ready    = 1'b1;
    tick;
    do_fetch(64'h1000, 32'hC0DE1000);
    do_fetch(64'h1004, 32'hC0DE1004);
    do_fetch(64'h1008, 32'hC0DE1008);
    do_fetch(64'h100C, 32'hC0DE100C);
    chk("full_count", 64'(queue_count), 64'd4);
    chk("full_no_req", 64'(req_valid), 64'd0);
    tick;
    tick;
    chk("full_stall_req", 64'(req_valid), 64'd0);
    chk("full_stall_count", 64'(queue_count), 64'd4);
    chk("head_pc0", out_pc, 64'h1000);

    req_ready = 1'b0;
    out_ready = 1'b1;
    chk("head_instr0", 64'(out_instr), 64'hC0DE1000);
    tick;
    chk("drain_pc1", out_pc, 64'h1004);
    chk("drain_instr1", 64'(out_instr), 64'hC0DE1004);
    tick;
    chk("drain_pc2", out_pc, 64'h1008);
    chk("drain_instr2", 64'(out_instr), 64'hC0DE1008);
    tick;
    chk("drain_pc3", out_pc, 64'h100C);
    chk("drain_instr3", 64'(out_instr), 64'hC0DE100C);
    tick;
    out_ready = 1'b0;
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(queue_count), 64'd0);
    chk("resume_req_valid", 64'(req_valid), 64'd1);
    chk("resume_req_addr", req_addr, 64'h1010);

    req_ready = 1'b1;
    tick;
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'hC0DE1010;
    tick;
    resp_valid = 1'b0;
    chk("k1_count", 64'(queue_count), 64'd1);
    chk("k1_out_pc", out_pc, 64'h1010);
    chk("k1_next_req", req_addr, 64'h1014);

    redirect_valid = 1'b1;
    redirect_addr  = 64'h2000;
    out_ready      = 1'b1;
    tick;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("rdi_out_valid", 64'(out_valid), 64'd0);
    chk("rdi_count", 64'(queue_count), 64'd0);
    chk("rdi_req_valid", 64'(req_valid), 64'd1);
    chk("rdi_hold0", req_addr, 64'h1014);
    tick;
    chk("rdi_hold1", req_addr, 64'h1014);
    tick;
    chk("rdi_hold2", req_addr, 64'h1014);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    chk("rdi_discard_noreq", 64'(req_valid), 64'd0);
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD1014;
    tick;
    resp_valid = 1'b0;
    chk("rdi_dropped_count", 64'(queue_count), 64'd0);
    chk("rdi_dropped_valid", 64'(out_valid), 64'd0);
    chk("rdi_target_valid", 64'(req_valid), 64'd1);
    chk("rdi_target_addr", req_addr, 64'h2000);

    req_ready = 1'b1;
    tick;
    req_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 64'h3002;
    tick;
    redirect_valid = 1'b0;
    chk("rdw_out_valid", 64'(out_valid), 64'd0);
    chk("rdw_noreq", 64'(req_valid), 64'd0);
    resp_valid = 1'b1;
    resp_data  = 32'hBAD02000;
    tick;
    resp_valid = 1'b0;
    chk("rdw_dropped", 64'(queue_count), 64'd0);
    chk("rdw_req_valid", 64'(req_valid), 64'd1);
    chk("rdw_aligned", req_addr, 64'h3000);

    req_ready = 1'b1;
    tick;
    req_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 64'hFFFF_FFFF_FFFF_FFFE;
    resp_valid     = 1'b1;
    resp_data      = 32'hC0DE3000;
    tick;
    redirect_valid = 1'b0;
    resp_valid     = 1'b0;
    chk("rdr_dropped", 64'(queue_count), 64'd0);
    chk("rdr_req_valid", 64'(req_valid), 64'd1);
    chk("rdr_req_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    req_ready = 1'b1;
    tick;
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'hC0DEFFFC;
    tick;
    resp_valid = 1'b0;
    chk("wrap_count", 64'(queue_count), 64'd1);
    chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_out_instr", 64'(out_instr), 64'hC0DEFFFC);
    chk("wrap_req_valid", 64'(req_valid), 64'd1);
    chk("wrap_req_addr", req_addr, 64'h0);

    req_ready = 1'b1;
    tick;
    req_ready    = 1'b0;
    fetch_enable = 1'b0;
    tick;
    chk("dis_wait_noreq", 64'(req_valid), 64'd0);
    resp_valid = 1'b1;
    resp_data  = 32'hC0DE0000;
    tick;
    resp_valid = 1'b0;
    chk("dis_enqueued", 64'(queue_count), 64'd2);
    chk("dis_noreq0", 64'(req_valid), 64'd0);
    tick;
    tick;
    chk("dis_noreq1", 64'(req_valid), 64'd0);
    chk("dis_count", 64'(queue_count), 64'd2);

    fetch_enable = 1'b1;
    tick;
    chk("reen_req_valid", 64'(req_valid), 64'd1);
    chk("reen_req_addr", req_addr, 64'h4);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    reset     = 1'b1;
    tick;
    chk_reset_state("midrst");
    reset        = 1'b0;
    fetch_enable = 1'b0;
    resp_valid   = 1'b1;
    resp_data    = 32'hDEADBEEF;
    tick;
    resp_valid = 1'b0;
    chk("late_resp_count", 64'(queue_count), 64'd0);
    chk("late_resp_valid", 64'(out_valid), 64'd0);
    chk("late_resp_noreq", 64'(req_valid), 64'd0);
    fetch_enable = 1'b1;
    tick;
    chk("post_rst_req_valid", 64'(req_valid), 64'd1);
    chk("post_rst_req_addr", req_addr, 64'h1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Parametrised instruction fetch unit with a prefetch queue. It runs ahead of decode: it issues sequential instruction-cache requests, buffers up to `DEPTH` fetched instructions with their PCs, and hands them to decode over a valid/ready interface. It sits between the PC/branch logic and the IF/ID boundary. A redirect flushes the queue and discards any in-flight stale response, so sequential fetch and decode overlap with no per-instruction latch handshake.

## Interface
- `ADDR_W`, 64, PC/address width
- `INSTR_W`, 32, instruction width (multiple of 8); fetch step `STEP = INSTR_W/8` bytes
- `DEPTH`, 4, queue entries (power of two, ≥2)
- `RESET_PC`, 64'h0, fetch PC after reset
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fetch_enable`  in  1  permits new cache requests
- `redirect_valid`  in  1  branch/jump redirect, single-cycle pulse
- `redirect_addr`  in  ADDR_W  redirect target; low log2(STEP) bits ignored (treated as 0)
- `req_valid`  out  1  cache request valid
- `req_addr`  out  ADDR_W  cache request address
- `req_ready`  in  1  cache accepts request this cycle
- `resp_valid`  in  1  cache returns data for the one outstanding request
- `resp_data`  in  INSTR_W  returned instruction
- `out_valid`  out  1  queue head valid toward decode
- `out_instr`  out  INSTR_W  head instruction
- `out_pc`  out  ADDR_W  head PC
- `out_ready`  in  1  decode consumes head this cycle
- `queue_count`  out  $clog2(DEPTH)+1  occupancy, for debug and perf counters

## Operation
- Reset values: `req_valid`=0, `req_addr`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `queue_count`=0, fetch_pc=RESET_PC, state IDLE.
- At most one cache request is outstanding. A slot is reserved at issue: issue only if `queue_count + outstanding < DEPTH`.
- FSM:
  - IDLE → ISSUE when `fetch_enable` and a free slot exist; `req_addr`=fetch_pc.
  - ISSUE: hold `req_valid` and `req_addr` stable until `req_ready`. On acceptance, fetch_pc += STEP (modulo 2^ADDR_W, wraps silently), then go to WAIT.
  - WAIT: on `resp_valid`, push {fetch address, `resp_data`} into the queue. Next state is ISSUE if enabled and a slot is free, else IDLE. The issue may happen the same cycle: a response and a new request can occur back-to-back.
  - DISCARD: wait for `resp_valid`, drop the data, then go to IDLE or ISSUE.
- Redirect has priority over every other event in its cycle:
  - Queue flushed; `out_valid`=0 next cycle; a concurrent `out_ready` pop is ignored.
  - fetch_pc ← aligned `redirect_addr`.
  - From WAIT, or from ISSUE with `req_ready` in the same cycle: go to DISCARD.
  - From ISSUE without `req_ready`: the request stays stable, is marked stale, and goes to DISCARD once accepted. The redirect address is issued afterwards.
  - A `resp_valid` arriving in the redirect cycle is dropped; the FSM then goes to IDLE/ISSUE, not DISCARD.
- `fetch_enable` low: no new issue. An outstanding request still completes and is enqueued. Decode keeps draining the queue.
- Queue full: the FSM stalls in IDLE. A simultaneous push and pop keeps the count unchanged.
- Queue empty: `out_valid`=0; `out_instr`/`out_pc` are don't-care.
- `resp_valid` with nothing outstanding is a protocol error; ignore it (assertion in the bench).

## Timing
- Request accepted in cycle T, `resp_valid` in cycle T+k (k≥1): entry visible at `out_valid` in T+k+1. No combinational path from response to output.
- Pop in cycle T: the next head is visible in T+1.
- Redirect in cycle T: `out_valid`=0 in T+1. The first request to the target is at T+1 if there is no outstanding request, otherwise the cycle after the stale response returns.
- Steady-state throughput with k=1: one instruction per 2 cycles.
- No combinational path from `out_ready` to `req_valid`, or from `req_ready` to `out_valid`.

## Structure
- Package `fetch_pkg`: `fetch_state_e` (IDLE, ISSUE, WAIT, DISCARD), `fetch_entry_t` struct {pc, instr} parameterised via localparams, and the STEP constant.
- Sub-module `fetch_fifo`: synchronous circular FIFO with push, pop, flush, count, and wrapping read/write pointers of $clog2(DEPTH) bits. Flush has priority over push/pop.
- The top level holds the FSM, fetch_pc, the outstanding/stale flags, and the slot-reservation check.

## Test plan
- Sequential fill: reset, `fetch_enable`=1, `out_ready`=0, cache k=1, RESET_PC=0x1000. Expect exactly 4 requests to 0x1000, 0x1004, 0x1008, 0x100C, then `req_valid` stays 0 and `queue_count`=4.
- Drain: continue the previous case with `out_ready`=1. Expect `out_pc` 0x1000..0x100C in order with matching `resp_data`, and fetch resumes at 0x1010.
- Redirect in WAIT: request 0x2000 outstanding, redirect to 0x3002. Expect the 0x2000 response dropped, `out_valid`=0 next cycle, and the next request at 0x3000.
- Redirect in ISSUE with `req_ready`=0 for 3 cycles: expect `req_addr` stable at the old address until accepted, its response discarded, then a request to the target.
- Wrap and stall: fetch_pc=0xFFFF_FFFF_FFFF_FFFC. Expect the next request at 0x0. Toggle `fetch_enable` low mid-WAIT: the response is still enqueued and no further request is issued.
- Reset mid-operation: assert `reset` during WAIT with the queue half full. Expect all outputs at their reset values the next cycle, and a late `resp_valid` ignored.
